i2s_dac_tx: RTL and testbench

- I2S transmitter for the WM8731 DAC path (AUD_DACLRCK / AUD_DACDAT); the playback-side counterpart of the ADC serial stream the recorder receives.
- Accepts parallel PCM samples over a valid/ready handshake into a small FIFO.
- Serializes one sample per LRCK frame, MSB-first, with the standard I2S one-bit delay.
- Sits between the audio DSP/player and the codec pins in Top.

---
 rtl/i2s_dac_tx.sv | 169 ++++++++++++++++
 tb/tb_i2s_dac_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: WM8731 I2S DAC serializer fed by a small sample FIFO.
// Define I2S_TX_UNDERRUN_CNT_EN to add the saturating o_underrun_cnt port.
module i2s_dac_tx #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter bit STEREO_DUP = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_aud_daclrck,
  input  logic              i_en,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_aud_dacdat,
  output logic              o_busy,
  output logic              o_underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       o_underrun_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W);

  typedef enum logic [1:0] {
    WAIT_SYNC,
    SHIFT,
    PAD
  } state_t;

  state_t state, state_n;

  logic              lrck_d;
  logic              fall, rise;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              empty, push, pop;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [DATA_W-1:0] cur, cur_n;
  logic [CW-1:0]     bcnt, bcnt_n;
  logic              ch, ch_n;
  logic              dat_n, busy_n, und_n;

  assign fall    = lrck_d & ~i_aud_daclrck;
  assign rise    = ~lrck_d & i_aud_daclrck;
  assign empty   = (count == '0);
  assign o_ready = (count != FULL_CNT);
  assign push    = i_valid & o_ready;
  assign pop     = fall & i_en & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (push && !i_flush) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // A fall always restarts the left channel, even mid-word (truncation).
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cur_n   = cur;
    bcnt_n  = bcnt;
    ch_n    = ch;
    dat_n   = 1'b0;
    busy_n  = o_busy;
    und_n   = 1'b0;
    if (fall) begin
      state_n = SHIFT;
      ch_n    = 1'b0;
      bcnt_n  = CW'(1);
      if (pop) begin
        shreg_n = head;
        cur_n   = head;
        dat_n   = head[DATA_W-1];
        busy_n  = 1'b1;
      end else begin
        shreg_n = '0;
        cur_n   = '0;
        busy_n  = 1'b0;
        und_n   = i_en;
      end
    end else if (rise && state != WAIT_SYNC) begin
      state_n = SHIFT;
      ch_n    = 1'b1;
      bcnt_n  = CW'(1);
      shreg_n = STEREO_DUP ? cur : '0;
      dat_n   = STEREO_DUP & cur[DATA_W-1];
    end else begin
      unique case (state)
        SHIFT: begin
          if (bcnt == LAST_BIT) begin
            state_n = PAD;
            if (ch) busy_n = 1'b0;
          end else begin
            dat_n   = shreg[DATA_W-2];
            shreg_n = shreg << 1;
            bcnt_n  = bcnt + 1'b1;
          end
        end
        WAIT_SYNC: ;
        PAD:       ;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= WAIT_SYNC;
      lrck_d       <= 1'b0;
      shreg        <= '0;
      cur          <= '0;
      bcnt         <= '0;
      ch           <= 1'b0;
      o_aud_dacdat <= 1'b0;
      o_busy       <= 1'b0;
      o_underrun   <= 1'b0;
    end else begin
      state        <= state_n;
      lrck_d       <= i_aud_daclrck;
      shreg        <= shreg_n;
      cur          <= cur_n;
      bcnt         <= bcnt_n;
      ch           <= ch_n;
      o_aud_dacdat <= dat_n;
      o_busy       <= busy_n;
      o_underrun   <= und_n;
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_underrun_cnt <= '0;
    end else if (i_flush) begin
      o_underrun_cnt <= '0;
    end else if (und_n && o_underrun_cnt != 16'hFFFF) begin
      o_underrun_cnt <= o_underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx: random and directed frames against a queue-based
// model of the I2S DAC transmitter.
module tb_i2s_dac_tx;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam bit DUP    = 1'b1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic lrck  = 1'b0;
  logic en    = 1'b0;
  logic flush = 1'b0;
  logic valid = 1'b0;
  logic [DATA_W-1:0] data = '0;
  logic ready, dacdat, busy, underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] ucnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] q[$];
  bit   synced, mbusy, mch, lrck_prev;
  int   pos, mucnt;
  logic [DATA_W-1:0] mw, mcur;

  always #5 clk = ~clk;

  i2s_dac_tx #(
    .DATA_W(DATA_W),
    .FIFO_DEPTH(DEPTH),
    .STEREO_DUP(DUP)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_aud_daclrck(lrck),
    .i_en(en),
    .i_flush(flush),
    .i_data(data),
    .i_valid(valid),
    .o_ready(ready),
    .o_aud_dacdat(dacdat),
    .o_busy(busy),
    .o_underrun(underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .o_underrun_cnt(ucnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // One clock: advance the model by the spec's rules, then compare.
  task automatic cycle();
    bit f, r, rdy, und;
    logic exp_dat;
    f   = lrck_prev && !lrck;
    r   = !lrck_prev && lrck;
    rdy = q.size() < DEPTH;
    und = 1'b0;
    if (f) begin
      mch = 1'b0; synced = 1'b1; pos = 0;
      if (en && q.size() > 0) begin
        mw = q.pop_front(); mbusy = 1'b1;
      end else begin
        mw = '0; mbusy = 1'b0; und = en;
      end
      mcur = mw;
    end else if (r && synced) begin
      mch = 1'b1; pos = 0;
      mw = DUP ? mcur : '0;
    end else if (pos <= DATA_W) begin
      pos++;
    end
    if (synced && mch && pos == DATA_W) mbusy = 1'b0;
    if (flush) begin
      q.delete();
      mucnt = 0;
    end else begin
      if (valid && rdy) q.push_back(data);
      if (und && mucnt < 65535) mucnt++;
    end
    lrck_prev = lrck;
    @(posedge clk);
    #1;
    exp_dat = (synced && pos < DATA_W) ? mw[DATA_W-1-pos] : 1'b0;
    chk("dacdat", dacdat, exp_dat);
    chk("busy", busy, mbusy);
    chk("underrun", underrun, und);
    chk("ready", ready, q.size() < DEPTH);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk("ucnt", ucnt, mucnt);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d);
    valid = 1'b1;
    data  = d;
    cycle();
    valid = 1'b0;
  endtask

  task automatic do_reset();
    valid = 1'b0;
    flush = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_dacdat", dacdat, 0);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", underrun, 0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk("rst_ucnt", ucnt, 0);
`endif
    q.delete();
    synced = 1'b0; mbusy = 1'b0; mch = 1'b0;
    mw = '0; mcur = '0; pos = DATA_W + 1;
    lrck_prev = 1'b0; mucnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic stir(input int k);
    valid = ($urandom_range(0, 2) == 0);
    data  = DATA_W'($urandom);
    flush = (k > 3) && ($urandom_range(0, 63) == 0);
  endtask

  task automatic frame(input bit en0, input int drop, input int hl,
                       input int hr, input bit rnd,
                       output logic [DATA_W-1:0] capl,
                       output logic [DATA_W-1:0] capr);
    capl = '0;
    capr = '0;
    en   = en0;
    lrck = 1'b0;
    for (int k = 0; k < hl; k++) begin
      if (rnd) stir(k);
      if (k == drop) en = 1'b0;
      cycle();
      if (k < DATA_W) capl = {capl[DATA_W-2:0], dacdat};
    end
    lrck = 1'b1;
    for (int k = 0; k < hr; k++) begin
      if (rnd) stir(k);
      cycle();
      if (k < DATA_W) capr = {capr[DATA_W-2:0], dacdat};
    end
    if (rnd) begin
      valid = 1'b0;
      flush = 1'b0;
    end
  endtask

  initial begin
    logic [DATA_W-1:0] cl, cr;
    #2;
    do_reset();

    lrck = 1'b1;
    idle(10);
    push_word(16'hA5C3);
    frame(1'b1, -1, 32, 32, 1'b0, cl, cr);
    chk("a5c3_left", cl, 16'hA5C3);
    chk("a5c3_right", cr, DUP ? 16'hA5C3 : 16'h0);

    for (int i = 1; i <= 4; i++) push_word(16'(i * 16'h1111));
    chk("full_ready", ready, 0);
    valid = 1'b1;
    data  = 16'h5555;
    idle(3);
    lrck = 1'b0;
    cycle();
    chk("ready_after_pop", ready, 1);
    cycle();
    valid = 1'b0;
    idle(30);
    lrck = 1'b1;
    idle(32);
    repeat (4) frame(1'b1, -1, 32, 32, 1'b0, cl, cr);
    chk("fill_last", cl, 16'h5555);

    repeat (3) frame(1'b1, -1, 32, 32, 1'b0, cl, cr);
    chk("underrun_zero", cl, 0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk("ucnt_three", ucnt, 3);
`endif

    flush = 1'b1;
    cycle();
    flush = 1'b0;
    push_word(16'h8001);
    push_word(16'h1234);
    frame(1'b1, 5, 32, 32, 1'b0, cl, cr);
    chk("endrop_left", cl, 16'h8001);
    chk("endrop_right", cr, DUP ? 16'h8001 : 16'h0);
    frame(1'b0, -1, 32, 32, 1'b0, cl, cr);
    chk("disabled_zero", cl, 0);
    frame(1'b1, -1, 32, 32, 1'b0, cl, cr);
    chk("held_sample", cl, 16'h1234);

    for (int i = 0; i < 4; i++) push_word(16'hC3A0 + 16'(i * 7));
    frame(1'b1, -1, 10, 12, 1'b0, cl, cr);
    frame(1'b1, -1, 17, 5, 1'b0, cl, cr);
    frame(1'b1, -1, 5, 40, 1'b0, cl, cr);
    frame(1'b1, -1, 16, 16, 1'b0, cl, cr);

    push_word(16'hFFFF);
    en   = 1'b1;
    lrck = 1'b0;
    idle(8);
    chk("pre_reset_busy", busy, 1);
    do_reset();
    idle(20);
    lrck = 1'b1;
    idle(32);
    push_word(16'hBEEF);
    frame(1'b1, -1, 32, 32, 1'b0, cl, cr);
    chk("resume", cl, 16'hBEEF);

    for (int f = 0; f < 24; f++) begin
      frame($urandom_range(0, 3) != 0, -1, $urandom_range(18, 40),
            $urandom_range(18, 40), 1'b1, cl, cr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
